// File: rtl/usb_in_ep_sched.sv
// Read-side scheduler for a USB IN endpoint: NAKs on empty FIFO, otherwise sends
// PID + up to MAXPKT payload bytes, then waits for the host ACK and advances the data toggle.
module usb_in_ep_sched #(
  parameter int unsigned MAXPKT      = 64,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_token,
  input  logic       hs_ack,
  input  logic       clr_toggle,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_valid,
  output logic       fifo_rd,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_eop,
  output logic       busy,
  output logic       toggle,
  output logic [7:0] drop_cnt
);

  localparam int unsigned CW = $clog2(MAXPKT + 1);
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NAK,
    S_PID,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_EOP,
    S_ACKWAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic          fetch_done;

  assign fetch_done = (cnt == CW'(MAXPKT)) || fifo_empty;
  // Decoded from the state register so a read can only ever happen in FETCH with data present.
  assign fifo_rd    = (state == S_FETCH) && !fetch_done;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      timer    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_eop   <= 1'b0;
      toggle   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      tx_eop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_token) begin
            cnt      <= '0;
            tx_valid <= 1'b1;
            if (fifo_empty) begin
              state   <= S_NAK;
              tx_data <= 8'h5A;
            end else begin
              state   <= S_PID;
              // A same-cycle clr_toggle already selects DATA0 for this packet.
              tx_data <= (toggle && !clr_toggle) ? 8'h4B : 8'hC3;
            end
          end
        end
        S_NAK: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_PID: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fetch_done) begin
            tx_eop <= 1'b1;
            state  <= S_EOP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // tx_data doubles as the payload byte register.
          if (fifo_valid) begin
            tx_data  <= fifo_dout;
            tx_valid <= 1'b1;
            cnt      <= cnt + 1'b1;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_EOP: begin
          timer <= TW'(ACK_TIMEOUT - 1);
          state <= S_ACKWAIT;
        end
        S_ACKWAIT: begin
          if (hs_ack) begin
            toggle <= ~toggle;
            state  <= S_IDLE;
          end else if (timer == '0) begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            state <= S_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (clr_toggle) toggle <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_in_ep_sched.sv
// Scoreboard bench for usb_in_ep_sched: a queue-based packet model predicts the byte stream,
// an independent monitor pops and compares every transferred byte and end-of-packet strobe.
module tb_usb_in_ep_sched;

  localparam int unsigned MAXPKT = 64;
  localparam int unsigned ACK_TO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_token = 1'b0;
  logic       hs_ack = 1'b0;
  logic       clr_toggle = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_valid = 1'b0;
  logic       fifo_rd;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       tx_eop;
  logic       busy;
  logic       toggle;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  usb_in_ep_sched #(.MAXPKT(MAXPKT), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst), .in_token(in_token), .hs_ack(hs_ack), .clr_toggle(clr_toggle),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid), .fifo_rd(fifo_rd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_eop(tx_eop),
    .busy(busy), .toggle(toggle), .drop_cnt(drop_cnt)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] mdl_q[$];
  logic [8:0] exp_q[$];
  bit         mdl_tog = 1'b0;
  int         mdl_drop = 0;
  int         rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Endpoint FIFO stand-in: read data one cycle after fifo_rd, empty flag registered.
  always @(posedge clk) begin
    fifo_valid <= 1'b0;
    if (fifo_rd && fifo_q.size() != 0) begin
      fifo_dout  <= fifo_q.pop_front();
      fifo_valid <= 1'b1;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 3) != 0);
      default: tx_ready = 1'b0;
    endcase
  end

  logic       pv = 1'b0;
  logic       phs = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !phs) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, pd);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_byte: got %0h expected nothing at %0t", tx_data, $time);
        end else chk("tx_byte", {1'b0, tx_data}, exp_q.pop_front());
      end
      if (tx_eop) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_eop: got eop expected nothing at %0t", $time);
        end else chk("tx_eop", {tx_eop, 8'h00}, exp_q.pop_front());
      end
      if (fifo_rd) begin
        chk("rd_when_empty", fifo_empty, 0);
        chk("rd_while_tx", tx_valid, 0);
      end
      pv  = tx_valid;
      pd  = tx_data;
      phs = tx_valid && tx_ready;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    mdl_q.push_back(b);
  endtask

  task automatic load_rand(input int n);
    for (int i = 0; i < n; i++) load_byte(8'($urandom));
    cyc(2);
  endtask

  task automatic issue_in(output bit data);
    int n;
    if (mdl_q.size() == 0) begin
      exp_q.push_back(9'h05A);
      data = 1'b0;
    end else begin
      exp_q.push_back(mdl_tog ? 9'h04B : 9'h0C3);
      n = (mdl_q.size() > MAXPKT) ? MAXPKT : mdl_q.size();
      repeat (n) exp_q.push_back({1'b0, mdl_q.pop_front()});
      exp_q.push_back(9'h100);
      data = 1'b1;
    end
    in_token = 1'b1;
    cyc(1);
    in_token = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && busy; i++) cyc(1);
    chk("idle_reached", busy, 0);
  endtask

  task automatic finish_pkt(input bit ack, input int dly, input bit clr);
    bit ok = 1'b0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge clk);
      if (tx_eop) ok = 1'b1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL eop_wait: got no tx_eop expected tx_eop within 6000 cycles");
    end
    cyc(1);
    if (ack) begin
      cyc(dly);
      hs_ack = 1'b1;
      clr_toggle = clr;
      cyc(1);
      hs_ack = 1'b0;
      clr_toggle = 1'b0;
      mdl_tog = clr ? 1'b0 : !mdl_tog;
    end else begin
      cyc(ACK_TO - 3);
      chk("still_ackwait", busy, 1);
      mdl_drop = (mdl_drop < 255) ? mdl_drop + 1 : 255;
    end
    wait_idle(ACK_TO + 20);
    chk("toggle", toggle, mdl_tog);
    chk("drop_cnt", drop_cnt, mdl_drop);
  endtask

  task automatic nak_in();
    bit d;
    issue_in(d);
    wait_idle(50);
    chk("toggle_nak", toggle, mdl_tog);
  endtask

  task automatic stall_until_send(input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    chk("send_reached", seen, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before 5ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit d;
    logic [7:0] b0;
    cyc(3);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_eop", tx_eop, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_toggle", toggle, 0);
    chk("rst_drop", drop_cnt, 0);

    // Empty FIFO: NAK only
    nak_in();

    // Three bytes, then a second packet that must carry DATA1
    load_byte(8'hA1); load_byte(8'hA2); load_byte(8'hA3);
    cyc(2);
    issue_in(d);
    finish_pkt(1'b1, 2, 1'b0);
    load_rand(1);
    issue_in(d);
    finish_pkt(1'b1, 0, 1'b0);

    // Max-size split: 70 bytes -> 64 + 6
    load_rand(70);
    issue_in(d);
    finish_pkt(1'b1, 3, 1'b0);
    chk("fifo_left", fifo_q.size(), 6);
    issue_in(d);
    finish_pkt(1'b1, 1, 1'b0);

    // Serializer stall in SEND; a token arriving meanwhile is ignored
    load_rand(3);
    b0 = mdl_q[0];
    issue_in(d);
    cyc(1);
    rdy_mode = 2;
    stall_until_send(20);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", tx_valid, 1);
      chk("stall_data", tx_data, b0);
      chk("stall_no_rd", fifo_rd, 0);
      if (i == 2) begin
        @(posedge clk); #1 in_token = 1'b1;
        @(posedge clk); #1 in_token = 1'b0;
      end
      @(negedge clk);
    end
    rdy_mode = 0;
    finish_pkt(1'b1, 4, 1'b0);

    // Timeout, stray ACK in idle, then clr_toggle beating the ACK flip
    load_rand(2);
    issue_in(d);
    finish_pkt(1'b0, 0, 1'b0);
    hs_ack = 1'b1; cyc(1); hs_ack = 1'b0; cyc(1);
    chk("stray_ack_toggle", toggle, mdl_tog);
    load_rand(1);
    issue_in(d);
    finish_pkt(1'b1, 2, 1'b1);

    // Randomised traffic
    rdy_mode = 1;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) != 0) load_rand($urandom_range(1, 100));
      if ($urandom_range(0, 4) == 0) begin
        clr_toggle = 1'b1; cyc(1); clr_toggle = 1'b0;
        mdl_tog = 1'b0;
      end
      issue_in(d);
      if (d) finish_pkt($urandom_range(0, 5) != 0, $urandom_range(0, 5), $urandom_range(0, 4) == 0);
      else wait_idle(100);
    end

    // Reset in the middle of a payload byte
    rdy_mode = 0;
    if (!mdl_tog) begin
      load_rand(1);
      issue_in(d);
      finish_pkt(1'b1, 0, 1'b0);
    end
    load_rand(10);
    issue_in(d);
    cyc(1);
    rdy_mode = 2;
    stall_until_send(20);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_fifo_rd", fifo_rd, 0);
    chk("mid_rst_toggle", toggle, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_eop", tx_eop, 0);
    exp_q.delete();
    fifo_q.delete();
    mdl_q.delete();
    mdl_tog = 1'b0;
    mdl_drop = 0;
    rdy_mode = 0;
    cyc(3);
    nak_in();
    load_rand(2);
    issue_in(d);
    finish_pkt(1'b1, 1, 1'b0);

    cyc(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
